// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clk cycles, publishes meas + 1-cycle meas_valid.
// Latency: sig_in rise to edge event 2-3 cycles; meas/ovf update on the edge ending the terminal gate cycle.
// No backpressure: meas is held until the next window; define FREQ_METER_SAT_EN for a saturating counter with ovf.
module freq_meter #(
  parameter int GATE_CYCLES = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] meas,
  output logic             meas_valid,
  output logic             ovf,
  output logic [7:0]       led
);

  localparam int TMR_W = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]       warm;
  logic             warm_done;
  logic             s1, s2, s3;
  logic             edge_evt;
  logic             capture;

  assign warm_done = (warm == 2'd3);
  assign edge_evt  = s2 & ~s3;

  // Synchronize the asynchronous input and keep one extra stage for rise detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Warm-up counter keeps the FSM idle until the synchronizer holds real input history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm <= 2'd0;
    end else if (!warm_done) begin
      warm <= warm + 2'd1;
    end
  end

  // Edge counter increment, wrapping or saturating depending on the build.
  always_comb begin
`ifdef FREQ_METER_SAT_EN
    cnt_inc = (edge_evt && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;
`else
    cnt_inc = cnt + CNT_W'(edge_evt);
`endif
  end

  // Next-state logic: gate windows run back-to-back; dropping en aborts and discards the partial count.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        cnt_nxt   = '0;
        if (warm_done && en) state_nxt = GATE;
      end
      GATE: begin
        if (!en) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          cnt_nxt   = '0;
        end else if (timer == TMR_LAST) begin
          capture   = 1'b1;
          timer_nxt = '0;
          cnt_nxt   = '0;
        end else begin
          timer_nxt = timer + 1'b1;
          cnt_nxt   = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, timer and edge-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture: the terminal-cycle edge event belongs to the closing window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meas       <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= capture;
      if (capture) meas <= cnt_inc;
    end
  end

`ifdef FREQ_METER_SAT_EN
  // Overflow flag reflects whether the just-closed window hit saturation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (capture) begin
      ovf <= (cnt_inc == {CNT_W{1'b1}});
    end
  end
`else
  assign ovf = 1'b0;
`endif

  // LED view: meas clamped to 8 bits; widened first so narrow CNT_W builds still work.
  always_comb begin
    logic [CNT_W+7:0] meas_w;
    meas_w = {8'd0, meas};
    led    = (meas_w > (CNT_W + 8)'(255)) ? 8'hFF : meas_w[7:0];
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: four instances with different gate lengths / widths.
// Vector table covers steady-state counts, LED clamp and overflow; hand sequences cover abort,
// terminal-cycle edges and reset with sig_in already high.
module tb_freq_meter;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [3:0]  man;
  logic [3:0]  gen;
  logic [3:0]  sig;
  int          per [4];
  int          ph  [4];

  logic [23:0] m0, m1, m2;
  logic [3:0]  m3;
  logic [3:0]  vld;
  logic [3:0]  ovf;
  logic [7:0]  led0, led1, led2, led3;

  int vecs;
  int miscompares;

  typedef struct {
    int sel;
    int per;
    int gate;
    int lo;
    int hi;
    int led_lo;
    int led_hi;
    int ovf;
  } vec_t;

  vec_t vt [5];

`ifdef FREQ_METER_SAT_EN
  localparam int SAT_MEAS = 15;
  localparam int SAT_OVF  = 1;
`else
  localparam int SAT_MEAS = 2;
  localparam int SAT_OVF  = 0;
`endif

  freq_meter #(.GATE_CYCLES(100), .CNT_W(24)) u_g100 (
    .clk(clk), .rst(rst), .sig_in(sig[0]), .en(en[0]),
    .meas(m0), .meas_valid(vld[0]), .ovf(ovf[0]), .led(led0));

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(24)) u_g1000 (
    .clk(clk), .rst(rst), .sig_in(sig[1]), .en(en[1]),
    .meas(m1), .meas_valid(vld[1]), .ovf(ovf[1]), .led(led1));

  freq_meter #(.GATE_CYCLES(1200), .CNT_W(24)) u_g1200 (
    .clk(clk), .rst(rst), .sig_in(sig[2]), .en(en[2]),
    .meas(m2), .meas_valid(vld[2]), .ovf(ovf[2]), .led(led2));

  freq_meter #(.GATE_CYCLES(200), .CNT_W(4)) u_w4 (
    .clk(clk), .rst(rst), .sig_in(sig[3]), .en(en[3]),
    .meas(m3), .meas_valid(vld[3]), .ovf(ovf[3]), .led(led3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sig_in per instance: generated square wave when per>0, else the manual level.
  always_comb begin
    sig = '0;
    for (int i = 0; i < 4; i++) sig[i] = (per[i] > 0) ? gen[i] : man[i];
  end

  initial begin
    gen = '0;
    for (int i = 0; i < 4; i++) ph[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (per[i] > 0) begin
          gen[i] = (ph[i] < per[i] / 2);
          ph[i]  = (ph[i] + 1) % per[i];
        end
      end
    end
  end

  function automatic int meas_of(int s);
    case (s)
      0:       return int'(m0);
      1:       return int'(m1);
      2:       return int'(m2);
      default: return int'(m3);
    endcase
  endfunction

  function automatic int led_of(int s);
    case (s)
      0:       return int'(led0);
      1:       return int'(led1);
      2:       return int'(led2);
      default: return int'(led3);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int lo, input int hi);
    vecs++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Wait for a meas_valid pulse on instance s; n = posedges consumed. Timeout counts as a miscompare.
  task automatic wait_valid(input int s, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (vld[s]) seen = 1'b1;
    end
    if (!seen) begin
      vecs++;
      miscompares++;
      $display("FAIL timeout: no meas_valid on instance %0d within %0d cycles", s, budget);
    end
  endtask

  task automatic do_reset(input int s, input int p);
    @(negedge clk);
    rst = 1'b0;
    en  = '0;
    for (int i = 0; i < 4; i++) per[i] = 0;
    man = '0;
    per[s] = p;
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    en[s] = 1'b1;
  endtask

  initial begin
    int n;
    int cnt;
    vecs        = 0;
    miscompares = 0;
    rst = 1'b0;
    en  = '0;
    man = '0;
    for (int i = 0; i < 4; i++) per[i] = 0;

    vt[0] = '{sel: 0, per: 10, gate: 100,  lo: 10,  hi: 10,  led_lo: 10,  led_hi: 10,  ovf: 0};
    vt[1] = '{sel: 1, per: 4,  gate: 1000, lo: 250, hi: 250, led_lo: 250, led_hi: 250, ovf: 0};
    vt[2] = '{sel: 1, per: 30, gate: 1000, lo: 33,  hi: 34,  led_lo: 33,  led_hi: 34,  ovf: 0};
    vt[3] = '{sel: 2, per: 4,  gate: 1200, lo: 300, hi: 300, led_lo: 255, led_hi: 255, ovf: 0};
    vt[4] = '{sel: 3, per: 4,  gate: 200,  lo: SAT_MEAS, hi: SAT_MEAS,
              led_lo: SAT_MEAS, led_hi: SAT_MEAS, ovf: SAT_OVF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_meas0", int'(m0), 0, 0);
    chk("rst_vld0",  int'(vld[0]), 0, 0);
    chk("rst_ovf0",  int'(ovf[0]), 0, 0);
    chk("rst_led0",  int'(led0), 0, 0);
    chk("rst_meas3", int'(m3), 0, 0);
    chk("rst_vld3",  int'(vld[3]), 0, 0);
    chk("rst_ovf3",  int'(ovf[3]), 0, 0);
    chk("rst_led3",  int'(led3), 0, 0);

    // Steady-state vectors: skip the first window, check the second.
    for (int v = 0; v < 5; v++) begin
      do_reset(vt[v].sel, vt[v].per);
      wait_valid(vt[v].sel, 2 * vt[v].gate + 20, n);
      wait_valid(vt[v].sel, 2 * vt[v].gate, n);
      chk($sformatf("v%0d_interval", v), n, vt[v].gate, vt[v].gate);
      chk($sformatf("v%0d_meas", v), meas_of(vt[v].sel), vt[v].lo, vt[v].hi);
      chk($sformatf("v%0d_led", v), led_of(vt[v].sel), vt[v].led_lo, vt[v].led_hi);
      chk($sformatf("v%0d_ovf", v), int'(ovf[vt[v].sel]), vt[v].ovf, vt[v].ovf);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse_width", v), int'(vld[vt[v].sel]), 0, 0);
    end

    // Abort: period 20 gives 5, drop en mid-window, resume at period 10.
    do_reset(0, 20);
    wait_valid(0, 250, n);
    wait_valid(0, 200, n);
    chk("abort_pre_meas", int'(m0), 5, 5);
    repeat (50) @(posedge clk);
    @(negedge clk);
    en[0]  = 1'b0;
    per[0] = 10;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (vld[0]) cnt++;
    end
    chk("abort_no_valid", cnt, 0, 0);
    chk("abort_meas_held", int'(m0), 5, 5);
    @(negedge clk);
    en[0] = 1'b1;
    wait_valid(0, 200, n);
    chk("abort_first_latency", n, 101, 101);
    chk("abort_new_meas", int'(m0), 10, 10);

    // Terminal-cycle edge: rise at cycle 97 gives an edge event in cycle 99.
    per[0] = 0;
    man[0] = 1'b0;
    wait_valid(0, 250, n);
    wait_valid(0, 150, n);
    repeat (97) @(posedge clk);
    @(negedge clk);
    man[0] = 1'b1;
    wait_valid(0, 10, n);
    chk("term_latency", n, 3, 3);
    chk("term_meas", int'(m0), 1, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    man[0] = 1'b0;
    repeat (88) @(posedge clk);
    @(negedge clk);
    man[0] = 1'b1;
    wait_valid(0, 10, n);
    chk("next_closing_meas", int'(m0), 0, 0);
    wait_valid(0, 120, n);
    chk("next_interval", n, 100, 100);
    chk("next_new_meas", int'(m0), 1, 1);

    // Async reset mid-window with sig_in high; warm-up must hide the high level.
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_meas", int'(m0), 0, 0);
    chk("midrst_vld", int'(vld[0]), 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_valid(0, 250, n);
    chk("warm_first_latency", n, 104, 104);
    chk("warm_first_meas", int'(m0), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
